// File: rtl/sys_defs.sv
// Shared system definitions: bus command encodings, widths and the data-memory request packet.
package sys_defs;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned NUM_MEM_TAGS = 15;
  localparam int unsigned TAG_W        = 4;
  localparam int unsigned WIDX_W       = XLEN - 2;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef struct packed {
    logic              valid;
    logic              is_store;
    logic [WIDX_W-1:0] word_idx;
    logic [XLEN-1:0]   data;
    logic [TAG_W-1:0]  tag;
  } DMEM_REQ;

  // Round-robin tag sequence 1..NUM_MEM_TAGS; tag 0 means "none".
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (t >= TAG_W'(NUM_MEM_TAGS)) ? TAG_W'(1) : t + TAG_W'(1);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor <-> data-memory bus: request fields from the processor, grant/completion from memory.
interface dmem_responder_if;
  import sys_defs::*;

  bus_command_t     proc2Dmem_command;
  logic [XLEN-1:0]  proc2Dmem_addr;
  logic [XLEN-1:0]  proc2Dmem_data;
  logic [TAG_W-1:0] Dmem2proc_response;
  logic [TAG_W-1:0] Dmem2proc_tag;
  logic [XLEN-1:0]  Dmem2proc_data;

  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data
  );

  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data
  );
endinterface

// File: rtl/mem_delay_line.sv
// Fixed-depth shift register of request packets; a packet pushed at an edge emerges DEPTH cycles later.
module mem_delay_line
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clock,
  input  logic    reset,
  input  DMEM_REQ push_req,
  output DMEM_REQ done_req
);

  DMEM_REQ stage [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= push_req;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign done_req = stage[DEPTH-1];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency tagged data memory: grants tags round-robin, completes requests in order after MEM_LATENCY cycles.
module dmem_responder
  import sys_defs::*;
#(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned DMEM_WORDS  = 256
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic [XLEN-1:0]         mem [DMEM_WORDS];
  logic [TAG_W-1:0]        tag_ptr;
  logic [NUM_MEM_TAGS:1]   inflight;
  logic [NUM_MEM_TAGS:1]   inflight_nxt;
  DMEM_REQ                 acc_req;
  DMEM_REQ                 done_req;
  logic [TAG_W-1:0]        done_tag;
  logic [IDX_W-1:0]        done_idx;
  logic                    addr_ok;
  logic                    tag_free;
  logic                    accept_c;
  logic                    unused_idx_hi;

  // Acceptance decision and packet capture; a tag retiring this cycle may be reissued at once.
  always_comb begin
    done_tag = done_req.valid ? done_req.tag : '0;
    addr_ok  = (bus.proc2Dmem_addr[1:0] == 2'b00) &&
               (bus.proc2Dmem_addr[XLEN-1:2] < WIDX_W'(DMEM_WORDS));
    tag_free = !inflight[tag_ptr] || (done_tag == tag_ptr);
    accept_c = reset && (bus.proc2Dmem_command != BUS_NONE) && addr_ok && tag_free;

    acc_req = '0;
    if (accept_c) begin
      acc_req.valid    = 1'b1;
      acc_req.is_store = (bus.proc2Dmem_command == BUS_STORE);
      acc_req.word_idx = bus.proc2Dmem_addr[XLEN-1:2];
      acc_req.data     = bus.proc2Dmem_data;
      acc_req.tag      = tag_ptr;
    end
  end

  // Retire before grant so a tag completing and reissued in the same cycle ends up busy.
  always_comb begin
    inflight_nxt = inflight;
    if (done_req.valid) inflight_nxt[done_req.tag] = 1'b0;
    if (accept_c)       inflight_nxt[tag_ptr]      = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_ptr  <= TAG_W'(1);
      inflight <= '0;
    end else begin
      if (accept_c) tag_ptr <= next_tag(tag_ptr);
      inflight <= inflight_nxt;
    end
  end

  mem_delay_line #(
    .DEPTH (MEM_LATENCY)
  ) u_delay (
    .clock    (clock),
    .reset    (reset),
    .push_req (acc_req),
    .done_req (done_req)
  );

  assign done_idx      = done_req.word_idx[IDX_W-1:0];
  assign unused_idx_hi = ^done_req.word_idx;

  // Storage is deliberately not reset; stores land at their completion edge.
  always_ff @(posedge clock) begin
    if (done_req.valid && done_req.is_store) mem[done_idx] <= done_req.data;
  end

  assign bus.Dmem2proc_response = accept_c ? tag_ptr : '0;
  assign bus.Dmem2proc_tag      = done_tag;
  assign bus.Dmem2proc_data     = (done_req.valid && !done_req.is_store) ? mem[done_idx] : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: per-cycle schedule-based model for two latencies plus directed literal checks.
module tb_dmem_responder;
  import sys_defs::*;

  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  dmem_responder #(.MEM_LATENCY(4), .DMEM_WORDS(256)) dut_a (
    .clock (clk), .reset (rst_n), .bus (ifa)
  );
  dmem_responder #(.MEM_LATENCY(20), .DMEM_WORDS(256)) dut_b (
    .clock (clk), .reset (rst_n), .bus (ifb)
  );

  // Model state: completions scheduled by absolute cycle, a word store, busy tags, next tag.
  int          sch_tag  [2][MAXC];
  bit          sch_st   [2][MAXC];
  int          sch_idx  [2][MAXC];
  logic [31:0] sch_data [2][MAXC];
  logic [31:0] mmem     [2][256];
  bit          mknown   [2][256];
  bit          busy     [2][16];
  int          ptr      [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_check(input int d, input int lat, input bus_command_t cmd,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] resp, input logic [3:0] tag,
                             input logic [31:0] rdata);
    int c;
    int done;
    bit ok;
    bit dknown;
    logic [31:0] e_data;
    c = cyc;
    if (!rst_n) begin
      chk($sformatf("rst_resp%0d", d), 32'(resp), 32'h0);
      chk($sformatf("rst_tag%0d", d), 32'(tag), 32'h0);
      chk($sformatf("rst_data%0d", d), rdata, 32'h0);
      ptr[d] = 1;
      for (int t = 0; t < 16; t++) busy[d][t] = 1'b0;
      for (int k = c; k < MAXC; k++) sch_tag[d][k] = 0;
      return;
    end
    done   = sch_tag[d][c];
    e_data = 32'h0;
    dknown = 1'b1;
    if (done != 0 && !sch_st[d][c]) begin
      if (mknown[d][sch_idx[d][c]]) e_data = mmem[d][sch_idx[d][c]];
      else dknown = 1'b0;
    end
    ok = (cmd != BUS_NONE) && (addr[1:0] == 2'b00) && (addr[31:2] < 30'd256) &&
         (!busy[d][ptr[d]] || done == ptr[d]);
    chk($sformatf("resp%0d", d), 32'(resp), ok ? 32'(ptr[d]) : 32'h0);
    chk($sformatf("tag%0d", d), 32'(tag), 32'(done));
    if (dknown) chk($sformatf("data%0d", d), rdata, e_data);
    if (done != 0) begin
      busy[d][done] = 1'b0;
      if (sch_st[d][c]) begin
        mmem[d][sch_idx[d][c]]   = sch_data[d][c];
        mknown[d][sch_idx[d][c]] = 1'b1;
      end
      sch_tag[d][c] = 0;
    end
    if (ok) begin
      busy[d][ptr[d]] = 1'b1;
      if (c + lat < MAXC) begin
        sch_tag[d][c+lat]  = ptr[d];
        sch_st[d][c+lat]   = (cmd == BUS_STORE);
        sch_idx[d][c+lat]  = int'(addr[31:2]);
        sch_data[d][c+lat] = wdata;
      end
      ptr[d] = (ptr[d] % 15) + 1;
    end
  endtask

  always @(negedge clk) begin
    model_check(0, 4, ifa.proc2Dmem_command, ifa.proc2Dmem_addr, ifa.proc2Dmem_data,
                ifa.Dmem2proc_response, ifa.Dmem2proc_tag, ifa.Dmem2proc_data);
    model_check(1, 20, ifb.proc2Dmem_command, ifb.proc2Dmem_addr, ifb.proc2Dmem_data,
                ifb.Dmem2proc_response, ifb.Dmem2proc_tag, ifb.Dmem2proc_data);
  end

  task automatic drive(input int d, input bus_command_t c, input logic [31:0] a, input logic [31:0] w);
    if (d == 0) begin
      ifa.proc2Dmem_command = c; ifa.proc2Dmem_addr = a; ifa.proc2Dmem_data = w;
    end else begin
      ifb.proc2Dmem_command = c; ifb.proc2Dmem_addr = a; ifb.proc2Dmem_data = w;
    end
  endtask

  task automatic idle_all();
    drive(0, BUS_NONE, 32'h0, 32'h0);
    drive(1, BUS_NONE, 32'h0, 32'h0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse(input int n);
    rst_n = 1'b0;
    idle_all();
    repeat (n) next();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    drive(0, BUS_LOAD, 32'h40, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_resp", 32'(ifa.Dmem2proc_response), 32'h0);
    end
    next();
    rst_n = 1'b1;

    // Illegal requests: misaligned and beyond the array
    drive(0, BUS_LOAD, 32'h42, 32'h0);
    @(negedge clk); chk("misaligned", 32'(ifa.Dmem2proc_response), 32'h0);
    next();
    drive(0, BUS_LOAD, 32'h400, 32'h0);
    @(negedge clk); chk("out_of_range", 32'(ifa.Dmem2proc_response), 32'h0);
    next();

    // Store then load the same word; pointer must still be at 1
    drive(0, BUS_STORE, 32'h40, 32'hDEADBEEF);
    @(negedge clk); chk("store_grant", 32'(ifa.Dmem2proc_response), 32'h1);
    next();
    drive(0, BUS_LOAD, 32'h40, 32'h0);
    @(negedge clk); chk("load_grant", 32'(ifa.Dmem2proc_response), 32'h2);
    next();
    idle_all();
    next();
    next();
    @(negedge clk);
    chk("store_done_tag", 32'(ifa.Dmem2proc_tag), 32'h1);
    chk("store_done_data", ifa.Dmem2proc_data, 32'h0);
    next();
    @(negedge clk);
    chk("load_done_tag", 32'(ifa.Dmem2proc_tag), 32'h2);
    chk("load_done_data", ifa.Dmem2proc_data, 32'hDEADBEEF);
    next();
    repeat (4) next();

    // Fill words 0x100.. with a known pattern
    for (int i = 0; i < 16; i++) begin
      drive(0, BUS_STORE, 32'h100 + 32'(4 * i), 32'hA5000000 + 32'(i));
      next();
    end
    idle_all();
    repeat (6) next();

    // 16 back-to-back loads: grants 1..15,1 and in-order completions 4 cycles later
    rst_pulse(2);
    for (int k = 0; k < 20; k++) begin
      if (k < 16) drive(0, BUS_LOAD, 32'h100 + 32'(4 * k), 32'h0);
      else idle_all();
      @(negedge clk);
      chk("b2b_grant", 32'(ifa.Dmem2proc_response), (k < 15) ? 32'(k + 1) : ((k == 15) ? 32'h1 : 32'h0));
      if (k >= 4) begin
        chk("b2b_tag", 32'(ifa.Dmem2proc_tag), 32'(((k - 4) % 15) + 1));
        chk("b2b_data", ifa.Dmem2proc_data, 32'hA5000000 + 32'(k - 4));
      end
      next();
    end
    idle_all();
    repeat (5) next();

    // Reset discards an in-flight store; the older word survives
    drive(0, BUS_STORE, 32'h80, 32'h12345678);
    next();
    idle_all();
    repeat (5) next();
    drive(0, BUS_STORE, 32'h80, 32'hBAD0BAD0);
    @(negedge clk); chk("doomed_store_grant", 32'(ifa.Dmem2proc_response), 32'h3);
    next();
    idle_all();
    next();
    rst_pulse(2);
    drive(0, BUS_LOAD, 32'h80, 32'h0);
    @(negedge clk);
    chk("post_rst_grant", 32'(ifa.Dmem2proc_response), 32'h1);
    chk("discarded_tag", 32'(ifa.Dmem2proc_tag), 32'h0);
    next();
    idle_all();
    repeat (3) next();
    @(negedge clk);
    chk("post_rst_tag", 32'(ifa.Dmem2proc_tag), 32'h1);
    chk("post_rst_data", ifa.Dmem2proc_data, 32'h12345678);
    next();

    // Inputs changing after acceptance must not leak into captured requests
    drive(0, BUS_STORE, 32'hC0, 32'h0000C0DE);
    next();
    drive(0, BUS_NONE, 32'hC4, 32'hFFFFFFFF);
    next();
    idle_all();
    repeat (3) next();
    drive(0, BUS_LOAD, 32'hC0, 32'h0);
    next();
    drive(0, BUS_NONE, 32'h80, 32'h55555555);
    next();
    idle_all();
    next();
    next();
    @(negedge clk);
    chk("capture_tag", 32'(ifa.Dmem2proc_tag), 32'h3);
    chk("capture_data", ifa.Dmem2proc_data, 32'h0000C0DE);
    next();
    repeat (4) next();

    // Latency 20: tag pointer stalls on busy tag 1 until it retires at cycle 20
    rst_pulse(2);
    for (int k = 0; k < 22; k++) begin
      drive(1, BUS_LOAD, 32'h0, 32'h0);
      @(negedge clk);
      chk("stall_grant", 32'(ifb.Dmem2proc_response),
          (k < 15) ? 32'(k + 1) : ((k < 20) ? 32'h0 : ((k == 20) ? 32'h1 : 32'h2)));
      if (k == 20) chk("stall_retire_tag", 32'(ifb.Dmem2proc_tag), 32'h1);
      next();
    end
    idle_all();
    repeat (25) next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter MEM_LATENCY, default 4, meaning cycles from request acceptance to response; legal range 1..20.
REQ-002 Parameter DMEM_WORDS, default 256, meaning number of 32-bit words stored.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 proc2Dmem_command  input  2  BUS_NONE / BUS_LOAD / BUS_STORE request from the retire stage.
REQ-006 proc2Dmem_addr  input  XLEN  byte address of request.
REQ-007 proc2Dmem_data  input  XLEN  store data.
REQ-008 Dmem2proc_response  output  4  tag granted this cycle; 0 = not accepted.
REQ-009 Dmem2proc_tag  output  4  tag completing this cycle; 0 = none.
REQ-010 Dmem2proc_data  output  XLEN  load data for the completing tag; 0 for stores.

Function
REQ-011 Dmem2proc_response shall be combinational from the request inputs and current state, in the same cycle the request is presented.
REQ-012 A request shall be accepted only if command is not BUS_NONE, addr[1:0]==0, word index addr[XLEN-1:2] < DMEM_WORDS, and the next tag is not in flight; otherwise response = 0 and no state changes.
REQ-013 Tags shall be issued round-robin 1,2,...,15,1; 0 is never issued; the tag pointer advances only on acceptance.
REQ-014 An in-flight bitmap of 15 tags shall be kept; a tag is set on acceptance and cleared in its completion cycle; a tag cleared and requested in the same cycle shall be accepted.
REQ-015 An accepted request shall complete exactly MEM_LATENCY cycles after its acceptance edge: Dmem2proc_tag = its tag for that one cycle only.
REQ-016 Completions shall be in acceptance order, at most one per cycle; Dmem2proc_tag = 0 and Dmem2proc_data = 0 in cycles with no completion.
REQ-017 Loads and stores shall access the array in their completion cycle: a store writes the full word at the completion edge; a load returns the array word combinationally in its completion cycle.
REQ-018 A load completing the cycle after a store to the same word shall return the stored value; no same-cycle conflict is possible under REQ-016.
REQ-019 Request fields (command, word index, data, tag) shall be captured at acceptance; later input changes shall not affect in-flight requests.
REQ-020 With MEM_LATENCY > 15, back-to-back requests shall see response = 0 once the tag pointer reaches a busy tag, until that tag completes.

Reset
REQ-021 While reset is low: response/tag/data outputs = 0, delay line empty, in-flight bitmap clear, tag pointer = 1.
REQ-022 Reset asserted mid-operation shall discard all in-flight requests without completion; stores not yet completed shall not write the array.
REQ-023 Array contents shall not be reset; reads of never-written words are undefined to the bench.

Structure
REQ-024 BUS_NONE/BUS_LOAD/BUS_STORE encodings, XLEN and NUM_MEM_TAGS (=15) shall come from the shared sys_defs package; a DMEM_REQ packet typedef (valid, is_store, word index, data, tag) shall be added there.
REQ-025 The fixed-latency delay line shall be a sub-module mem_delay_line, parameterised by depth, shifting one DMEM_REQ per cycle.
REQ-026 Target size 120-400 lines of RTL total.

Verification
REQ-027 Store 0xDEADBEEF to 0x40 at cycle 0, load 0x40 at cycle 1 (MEM_LATENCY=4) -> response 1 then 2; tag 1 at cycle 4 with data 0; tag 2 at cycle 5 with data 0xDEADBEEF.
REQ-028 Load to 0x42 (misaligned) and to 0x400 (DMEM_WORDS=256) -> response 0 both cycles; no completion; tag pointer stays 1.
REQ-029 16 back-to-back loads -> responses 1..15 then 1; completions in the same order, one per cycle, latency 4 each.
REQ-030 MEM_LATENCY=20, 17 consecutive loads -> responses 1..15, then 0 until tag 1 completes at cycle 20, where the request in that cycle gets tag 1.
REQ-031 Store to 0x80 accepted, reset pulsed low 2 cycles later, then load 0x80 -> no completion for the store tag; load returns prior word, not the store data.
REQ-032 Change proc2Dmem_addr/data in the cycle after acceptance -> completion reflects captured values only.
